// File: rtl/conv_window_if.sv
// ---------------------------------------------------------------------------
// conv_window_if
// Pixel stream bundle for conv_window_engine.
//   px_in_data / px_in_valid / px_in_ready : raster-order input stream
//   px_out_data / px_out_last_x / px_out_last_y / px_out_valid / px_out_ready :
//     window results; last_x marks the final column of a row and last_y the
//     final row of a frame.
// The slave modport is the engine's view; the master modport is the view of
// whatever feeds pixels in and drains results.
// ---------------------------------------------------------------------------
interface conv_window_if #(
  parameter int PB = 8,
  parameter int OB = 12
) ();
  logic [PB-1:0] px_in_data;
  logic          px_in_valid;
  logic          px_in_ready;
  logic [OB-1:0] px_out_data;
  logic          px_out_last_x;
  logic          px_out_last_y;
  logic          px_out_valid;
  logic          px_out_ready;

  modport slave (
    input  px_in_data, px_in_valid, px_out_ready,
    output px_in_ready, px_out_data, px_out_last_x, px_out_last_y, px_out_valid
  );

  modport master (
    output px_in_data, px_in_valid, px_out_ready,
    input  px_in_ready, px_out_data, px_out_last_x, px_out_last_y, px_out_valid
  );
endinterface

// File: rtl/conv_window_engine.sv
// ---------------------------------------------------------------------------
// conv_window_engine
// Streaming KxK sliding-window reducer. Pixels arrive in raster order; K-1
// line buffers plus a KxK window register expose every fully populated
// window, and each one is reduced to either the sum or the maximum of its
// pixels. One pixel per cycle is sustained when the output is drained.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   start      : one-cycle pulse, latches cfg_* and starts a frame (IDLE only)
//   cfg_width  : pixels per row
//   cfg_height : rows per frame
//   cfg_mode   : 0 = window sum, 1 = window max
//   done       : one-cycle end-of-frame pulse
//   cfg_err    : sticky, set when a frame is started smaller than the kernel
//   px         : pixel input / result output streams (conv_window_if.slave)
// ---------------------------------------------------------------------------
module conv_window_engine #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int K  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XB-1:0]   cfg_width,
  input  logic [YB-1:0]   cfg_height,
  input  logic            cfg_mode,
  output logic            done,
  output logic            cfg_err,
  conv_window_if.slave    px
);

  localparam int OB = PB + $clog2(K*K);
  localparam int CW = XB + YB;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q,    state_d;
  logic [XB-1:0]   width_q,    width_d;
  logic [YB-1:0]   height_q,   height_d;
  logic            mode_q,     mode_d;
  logic [CW-1:0]   total_q,    total_d;
  logic [CW-1:0]   in_cnt_q,   in_cnt_d;
  logic [XB-1:0]   x_q,        x_d;
  logic [YB-1:0]   y_q,        y_d;
  logic [OB-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            last_x_q,   last_x_d;
  logic            last_y_q,   last_y_d;
  logic            done_q,     done_d;
  logic            cfg_err_q,  cfg_err_d;

  // Line buffer j holds row y-1-j at column x; window row K-1 is the newest.
  logic [PB-1:0]   line_buf [K-1][1<<XB];
  logic [PB-1:0]   win_q    [K][K];
  logic [PB-1:0]   win_d    [K][K];
  logic [PB-1:0]   col_new  [K];

  logic            in_ready;
  logic            in_fire;
  logic            out_fire;
  logic            at_last_x;
  logic            produce;
  logic [OB-1:0]   win_sum;
  logic [PB-1:0]   win_max;

  // Input stalls whenever a held result would be overwritten, so a pending
  // output is never lost and a draining output never costs a bubble.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || px.px_out_ready)
                     && (in_cnt_q < total_q);
  assign in_fire   = px.px_in_valid && in_ready;
  assign out_fire  = out_valid_q && px.px_out_ready;
  assign at_last_x = (x_q == width_q - XB'(1));
  assign produce   = in_fire && (x_q >= XB'(K-1)) && (y_q >= YB'(K-1));

  // New window column and the shifted window it produces.
  always_comb begin
    col_new[K-1] = px.px_in_data;
    for (int j = 0; j < K-1; j++) begin
      col_new[K-2-j] = line_buf[j][x_q];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = col_new[r];
    end
  end

  // Reduce the shifted window; OB is wide enough that the sum cannot wrap.
  always_comb begin
    win_sum = '0;
    win_max = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_sum = win_sum + OB'(win_d[r][c]);
        if (win_d[r][c] > win_max) win_max = win_d[r][c];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    mode_d      = mode_q;
    total_d     = total_q;
    in_cnt_d    = in_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_x_d    = last_x_q;
    last_y_d    = last_y_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = cfg_width;
          height_d = cfg_height;
          mode_d   = cfg_mode;
          total_d  = CW'(cfg_width) * CW'(cfg_height);
          in_cnt_d = '0;
          x_d      = '0;
          y_d      = '0;
          if ((cfg_width < XB'(K)) || (cfg_height < YB'(K))) begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
            done_d    = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Only the final result of a frame carries both flags.
        if (out_fire && last_x_q && last_y_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_fire) begin
      in_cnt_d = in_cnt_q + CW'(1);
      if (at_last_x) begin
        x_d = '0;
        y_d = y_q + YB'(1);
      end else begin
        x_d = x_q + XB'(1);
      end
    end

    if (produce) begin
      out_data_d  = mode_q ? OB'(win_max) : win_sum;
      last_x_d    = at_last_x;
      last_y_d    = (y_q == height_q - YB'(1));
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values
    // regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      mode_q      <= 1'b0;
      total_q     <= '0;
      in_cnt_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_x_q    <= 1'b0;
      last_y_q    <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      mode_q      <= mode_d;
      total_q     <= total_d;
      in_cnt_q    <= in_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_x_q    <= last_x_d;
      last_y_q    <= last_y_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // NOTE: line buffers and window carry no reset; results are only emitted
  // once every window pixel has been rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      line_buf[0][x_q] <= px.px_in_data;
      for (int j = 1; j < K-1; j++) begin
        line_buf[j][x_q] <= line_buf[j-1][x_q];
      end
      win_q <= win_d;
    end
  end

  assign px.px_in_ready   = in_ready;
  assign px.px_out_data   = out_data_q;
  assign px.px_out_last_x = last_x_q;
  assign px.px_out_last_y = last_y_q;
  assign px.px_out_valid  = out_valid_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_conv_window_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_window_engine
// Directed and randomised frames through a K=3 and a K=5 engine. Expected
// results come from a reference window model pushed to a scoreboard when a
// frame starts; a negedge monitor pops and compares every output transfer.
// ---------------------------------------------------------------------------
module tb_conv_window_engine;
  localparam int XB  = 10;
  localparam int YB  = 10;
  localparam int PB  = 8;
  localparam int OB3 = PB + $clog2(9);
  localparam int OB5 = PB + $clog2(25);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XB-1:0] cfg_width;
  logic [YB-1:0] cfg_height;
  logic          cfg_mode;
  logic          in_valid;
  logic [PB-1:0] in_data;
  logic          out_ready;
  int            sel;

  always #5 clk = ~clk;

  conv_window_if #(.PB(PB), .OB(OB3)) if3 ();
  conv_window_if #(.PB(PB), .OB(OB5)) if5 ();

  logic start3, start5, done3, done5, err3, err5;
  assign start3 = start && (sel == 0);
  assign start5 = start && (sel == 1);
  assign if3.px_in_valid  = in_valid && (sel == 0);
  assign if5.px_in_valid  = in_valid && (sel == 1);
  assign if3.px_in_data   = in_data;
  assign if5.px_in_data   = in_data;
  assign if3.px_out_ready = out_ready;
  assign if5.px_out_ready = out_ready;

  conv_window_engine #(.XB(XB), .YB(YB), .PB(PB), .K(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_mode(cfg_mode), .done(done3),
    .cfg_err(err3), .px(if3)
  );

  conv_window_engine #(.XB(XB), .YB(YB), .PB(PB), .K(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_mode(cfg_mode), .done(done5),
    .cfg_err(err5), .px(if5)
  );

  // Observed view of whichever engine is selected.
  logic           mon_valid, mon_lx, mon_ly, mon_in_ready, mon_done, mon_err;
  logic [OB5-1:0] mon_data;
  always_comb begin
    mon_valid    = if3.px_out_valid;
    mon_lx       = if3.px_out_last_x;
    mon_ly       = if3.px_out_last_y;
    mon_in_ready = if3.px_in_ready;
    mon_done     = done3;
    mon_err      = err3;
    mon_data     = OB5'(if3.px_out_data);
    if (sel == 1) begin
      mon_valid    = if5.px_out_valid;
      mon_lx       = if5.px_out_last_x;
      mon_ly       = if5.px_out_last_y;
      mon_in_ready = if5.px_in_ready;
      mon_done     = done5;
      mon_err      = err5;
      mon_data     = if5.px_out_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [OB5-1:0] data;
    logic           lx;
    logic           ly;
  } exp_t;

  exp_t           sb[$];
  logic [OB5-1:0] obs_q[$];
  int             pix [64];
  int             in_idx, cur_w, cur_k, out_cnt, done_cnt, done_base;
  bit             exp_valid_pend, exp_done_pend;

  // Reference model: one entry per fully populated window, raster order.
  function automatic void push_model(input int w, input int h, input int k, input int mode);
    exp_t e;
    int   s, m, v;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x >= k-1 && y >= k-1) begin
          s = 0;
          m = 0;
          for (int dy = 0; dy < k; dy++) begin
            for (int dx = 0; dx < k; dx++) begin
              v = pix[(y-dy)*w + (x-dx)];
              s += v;
              if (v > m) m = v;
            end
          end
          e.data = OB5'((mode != 0) ? m : s);
          e.lx   = (x == w-1);
          e.ly   = (y == h-1);
          sb.push_back(e);
        end
      end
    end
  endfunction

  // Monitor: handshakes are judged at negedge for the following posedge.
  initial begin
    exp_t e;
    int   mx, my;
    in_idx = 0; cur_w = 1; cur_k = 3; out_cnt = 0; done_cnt = 0;
    exp_valid_pend = 0; exp_done_pend = 0;
    forever begin
      @(negedge clk);
      if (exp_valid_pend) check("out_latency", mon_valid, 1);
      if (exp_done_pend)  check("done_after_last", mon_done, 1);
      exp_valid_pend = 0;
      exp_done_pend  = 0;
      if (mon_done) done_cnt++;
      if (in_valid && mon_in_ready) begin
        mx = in_idx % cur_w;
        my = in_idx / cur_w;
        exp_valid_pend = (mx >= cur_k-1) && (my >= cur_k-1);
        in_idx++;
      end
      if (mon_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", mon_data, e.data);
          check("out_last_x", mon_lx, e.lx);
          check("out_last_y", mon_ly, e.ly);
        end
        obs_q.push_back(mon_data);
        out_cnt++;
        if (mon_lx && mon_ly) exp_done_pend = 1;
      end
    end
  end

  task automatic start_frame(input int w, input int h, input int mode, input int k);
    cfg_width  = XB'(w);
    cfg_height = YB'(h);
    cfg_mode   = mode[0];
    push_model(w, h, k, mode);
    obs_q.delete();
    in_idx    = 0;
    cur_w     = w;
    cur_k     = k;
    out_cnt   = 0;
    done_base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_frame(input int n, input int vpct, input int rpct,
                             input int stall, input int max_cyc);
    int             idx = 0;
    int             cyc = 0;
    logic [OB5-1:0] hold;
    while (done_cnt == done_base && cyc < max_cyc) begin
      if (stall > 0 && mon_valid) begin
        out_ready = 1'b0;
        in_valid  = (idx < n);
        in_data   = (idx < n) ? PB'(pix[idx]) : '0;
        hold      = (sb.size() > 0) ? sb[0].data : '0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall_in_ready", mon_in_ready, 0);
          check("stall_hold_data", mon_data, hold);
          check("stall_hold_valid", mon_valid, 1);
          @(posedge clk); #1;
          cyc++;
        end
        stall = 0;
      end
      // Valid stays high past the last pixel to probe that nothing extra is taken.
      in_valid  = (idx < n) ? ($urandom_range(99) < vpct) : 1'b1;
      in_data   = (idx < n) ? PB'(pix[idx]) : '0;
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && mon_in_ready && idx < n) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("frame_done_seen", done_cnt - done_base, 1);
    check("inputs_accepted", in_idx, n);
    repeat (3) @(posedge clk);
    #1;
    check("done_single_pulse", done_cnt - done_base, 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_outs(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    int exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    check({tag, "_count"}, obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) check(tag, obs_q[i], exp_v[i]);
  endtask

  initial begin
    int acc;
    sel = 0; rst = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
    cfg_mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", mon_in_ready, 0);
    check("rst_out_valid", mon_valid, 0);
    check("rst_out_data", mon_data, 0);
    check("rst_last_x", mon_lx, 0);
    check("rst_last_y", mon_ly, 0);
    check("rst_done", mon_done, 0);
    check("rst_cfg_err", mon_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp, window sum, free-flowing output.
    for (int i = 0; i < 16; i++) pix[i] = i;
    start_frame(4, 4, 0, 3);
    drive_frame(16, 100, 100, 0, 500);
    check_outs("sum_ramp", 45, 54, 81, 90);

    // Same frame, window max; config churn and a start during RUN are ignored.
    start_frame(4, 4, 1, 3);
    cfg_width = XB'(7); cfg_height = YB'(9); cfg_mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_frame(16, 100, 100, 0, 500);
    check_outs("max_ramp", 10, 11, 14, 15);

    // Output back-pressure on the first result for 5 cycles.
    start_frame(4, 4, 0, 3);
    drive_frame(16, 100, 100, 5, 500);
    check_outs("stall_ramp", 45, 54, 81, 90);

    // Frame narrower than the kernel.
    start_frame(2, 4, 0, 3);
    @(negedge clk);
    check("bad_cfg_done", mon_done, 1);
    check("bad_cfg_err", mon_err, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bad_cfg_in_ready", mon_in_ready, 0);
    end
    in_valid = 1'b0;
    check("bad_cfg_outputs", out_cnt, 0);
    check("bad_cfg_inputs", in_idx, 0);
    check("bad_cfg_done_pulses", done_cnt - done_base, 1);
    check("bad_cfg_err_sticky", mon_err, 1);
    @(posedge clk); #1;

    // Abandon a frame with reset after 7 pixels, then an all-255 frame.
    start_frame(4, 4, 0, 3);
    @(negedge clk);
    check("cfg_err_cleared", mon_err, 0);
    @(posedge clk); #1;
    acc = 0;
    for (int c = 0; c < 50 && acc < 7; c++) begin
      in_valid = 1'b1;
      in_data  = PB'(pix[acc]);
      @(negedge clk);
      if (mon_in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("partial_accepted", acc, 7);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_in_ready", mon_in_ready, 0);
    check("midrst_out_valid", mon_valid, 0);
    check("midrst_out_data", mon_data, 0);
    check("midrst_done", mon_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pix[i] = 255;
    start_frame(4, 4, 0, 3);
    drive_frame(16, 100, 100, 0, 500);
    check_outs("all_255", 2295, 2295, 2295, 2295);

    // Randomised handshakes, 8x6 frames, K=3 then K=5.
    for (int i = 0; i < 48; i++) pix[i] = $urandom_range(255);
    start_frame(8, 6, 0, 3);
    drive_frame(48, 60, 60, 0, 2000);
    check("rand_k3_count", out_cnt, 24);

    sel = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 48; i++) pix[i] = $urandom_range(255);
    start_frame(8, 6, 1, 5);
    drive_frame(48, 60, 60, 0, 2000);
    check("rand_k5_max_count", out_cnt, 8);

    start_frame(8, 6, 0, 5);
    drive_frame(48, 70, 50, 0, 2000);
    check("rand_k5_sum_count", out_cnt, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
